// File: rtl/add_acc_pkg.sv
// Shared defaults, mode encoding and saturation clamp helper for the lab accumulator.
package add_acc_pkg;

    localparam int unsigned DEF_W     = 2;
    localparam int unsigned DEF_ACC_W = 4;
    localparam int unsigned DEF_CNT_W = 4;
    localparam int unsigned MAX_ACC_W = 64;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } acc_mode_t;

    // Clamp value for an acc_w-bit accumulator; the caller truncates to its width.
    function automatic logic [MAX_ACC_W-1:0] sat_limit(input logic is_signed,
                                                       input logic neg,
                                                       input int unsigned acc_w);
        logic [MAX_ACC_W-1:0] one;
        logic [MAX_ACC_W-1:0] smin;
        one  = MAX_ACC_W'(1);
        smin = one << (acc_w - 1);
        if (!is_signed) begin
            sat_limit = (one << acc_w) - one;
        end else if (neg) begin
            sat_limit = smin;
        end else begin
            sat_limit = smin - one;
        end
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus a single-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= in;
            s2   <= s1;
            prev <= s2;
        end
    end

    // A held button yields one pulse; prev is cleared by rst so a press held through reset adds once.
    assign pulse = s2 & ~prev;

endmodule

// File: rtl/add_accumulate_flags.sv
// Board-level accumulator: step button adds in_a to a running sum with carry/overflow flags and add count.
module add_accumulate_flags
    import add_acc_pkg::*;
#(
    parameter int unsigned W          = DEF_W,
    parameter int unsigned ACC_W      = DEF_ACC_W,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_a,
    input  logic             step,
    input  logic             clear,
    input  logic             mode_signed,
    input  logic             saturate,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [CNT_W-1:0] out_count
);

    localparam logic INV = ACTIVE_LOW;

    logic [W-1:0]     a;
    logic             clr;
    logic             sat;
    logic             step_i;
    acc_mode_t        mode;
    logic             add_pulse;

    logic [ACC_W-1:0] acc;
    logic             carry;
    logic             ovf;
    logic [CNT_W-1:0] count;

    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   sum;
    logic             carry_n;
    logic             ovf_n;
    logic             sat_hit;
    logic [ACC_W-1:0] acc_n;

    // Pin polarity normalisation; rst is never inverted.
    assign a      = in_a ^ {W{INV}};
    assign clr    = clear ^ INV;
    assign sat    = saturate ^ INV;
    assign step_i = step ^ INV;
    assign mode   = acc_mode_t'(mode_signed ^ INV);

    btn_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .in    (step_i),
        .pulse (add_pulse)
    );

    always_comb begin
        ext     = {{(ACC_W-W){1'b0}}, a};
        acc_n   = '0;
        sat_hit = 1'b0;
        if (mode == MODE_SIGNED) begin
            ext = {{(ACC_W-W){a[W-1]}}, a};
        end
        sum     = {1'b0, acc} + {1'b0, ext};
        carry_n = sum[ACC_W];
        ovf_n   = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        // Saturation keys off the flag matching the mode selected for this add.
        sat_hit = (mode == MODE_SIGNED) ? ovf_n : carry_n;
        if (sat && sat_hit) begin
            acc_n = ACC_W'(sat_limit(mode == MODE_SIGNED, acc[ACC_W-1], ACC_W));
        end else begin
            acc_n = sum[ACC_W-1:0];
        end
    end

    // Clear outranks a coincident add, which is dropped.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (add_pulse) begin
            acc   <= acc_n;
            carry <= carry_n;
            ovf   <= ovf_n;
            count <= count + CNT_W'(1);
        end
    end

    assign out_acc   = acc ^ {ACC_W{INV}};
    assign out_carry = carry ^ INV;
    assign out_ovf   = ovf ^ INV;
    assign out_zero  = (acc == '0) ^ INV;
    assign out_neg   = acc[ACC_W-1] ^ INV;
    assign out_count = count ^ {CNT_W{INV}};

endmodule
